// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags. Sources are returned either as a
// ready value (register, commit bypass or RoB forward) or as the RoB tag still to wait on.
module reg_file #(
  parameter int unsigned ROB_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             issue_en,
  input  logic [4:0]       issue_rd,
  input  logic [ROB_W-1:0] issue_rob_id,
  input  logic [4:0]       commit_rd,
  input  logic [ROB_W-1:0] commit_rob_id,
  input  logic [31:0]      commit_value,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic             rs1_ready,
  output logic             rs2_ready,
  output logic [31:0]      rs1_value,
  output logic [31:0]      rs2_value,
  output logic [ROB_W-1:0] rs1_rob_id,
  output logic [ROB_W-1:0] rs2_rob_id,
  output logic [ROB_W-1:0] get_rob_id1,
  output logic [ROB_W-1:0] get_rob_id2,
  input  logic             get_ready1,
  input  logic             get_ready2,
  input  logic [31:0]      get_value1,
  input  logic [31:0]      get_value2
);

  logic [31:0]      value_q [32];
  logic [31:0]      value_d [32];
  logic [ROB_W-1:0] tag_q   [32];
  logic [ROB_W-1:0] tag_d   [32];
  logic [31:0]      busy_q;
  logic [31:0]      busy_d;

  // Commit value write always lands; clear and issue only touch busy/tag, issue winning over
  // the commit's busy clear on the same register.
  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    busy_d  = busy_q;
    if (rdy) begin
      if (commit_rd != 5'd0) begin
        value_d[commit_rd] = commit_value;
        if (busy_q[commit_rd] && (tag_q[commit_rd] == commit_rob_id)) begin
          busy_d[commit_rd] = 1'b0;
        end
      end
      if (clear) begin
        busy_d = '0;
        for (int i = 0; i < 32; i++) begin
          tag_d[i] = '0;
        end
      end else if (issue_en && (issue_rd != 5'd0)) begin
        busy_d[issue_rd] = 1'b1;
        tag_d[issue_rd]  = issue_rob_id;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
      busy_q <= '0;
    end else begin
      value_q <= value_d;
      tag_q   <= tag_d;
      busy_q  <= busy_d;
    end
  end

  assign get_rob_id1 = tag_q[rs1];
  assign get_rob_id2 = tag_q[rs2];

  always_comb begin
    rs1_ready  = 1'b0;
    rs1_value  = '0;
    rs1_rob_id = tag_q[rs1];
    if ((rs1 == 5'd0) || !busy_q[rs1]) begin
      rs1_ready  = 1'b1;
      rs1_value  = value_q[rs1];
      rs1_rob_id = '0;
    end else if ((commit_rd == rs1) && (commit_rob_id == tag_q[rs1]) && rdy) begin
      rs1_ready  = 1'b1;
      rs1_value  = commit_value;
      rs1_rob_id = '0;
    end else if (get_ready1) begin
      rs1_ready  = 1'b1;
      rs1_value  = get_value1;
      rs1_rob_id = '0;
    end
  end

  always_comb begin
    rs2_ready  = 1'b0;
    rs2_value  = '0;
    rs2_rob_id = tag_q[rs2];
    if ((rs2 == 5'd0) || !busy_q[rs2]) begin
      rs2_ready  = 1'b1;
      rs2_value  = value_q[rs2];
      rs2_rob_id = '0;
    end else if ((commit_rd == rs2) && (commit_rob_id == tag_q[rs2]) && rdy) begin
      rs2_ready  = 1'b1;
      rs2_value  = commit_value;
      rs2_rob_id = '0;
    end else if (get_ready2) begin
      rs2_ready  = 1'b1;
      rs2_value  = get_value2;
      rs2_rob_id = '0;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: rename, commit bypass, stale commit, clear, rdy stall, reset.
module tb_reg_file;

  localparam int unsigned ROB_W = 4;

  logic             clk = 1'b0;
  logic             rst, rdy, clear, issue_en;
  logic [4:0]       issue_rd, commit_rd, rs1, rs2;
  logic [ROB_W-1:0] issue_rob_id, commit_rob_id;
  logic [31:0]      commit_value, get_value1, get_value2;
  logic             get_ready1, get_ready2;
  logic             rs1_ready, rs2_ready;
  logic [31:0]      rs1_value, rs2_value;
  logic [ROB_W-1:0] rs1_rob_id, rs2_rob_id, get_rob_id1, get_rob_id2;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  reg_file #(.ROB_W(ROB_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .issue_en(issue_en), .issue_rd(issue_rd), .issue_rob_id(issue_rob_id),
    .commit_rd(commit_rd), .commit_rob_id(commit_rob_id), .commit_value(commit_value),
    .rs1(rs1), .rs2(rs2),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .rs1_value(rs1_value), .rs2_value(rs2_value),
    .rs1_rob_id(rs1_rob_id), .rs2_rob_id(rs2_rob_id),
    .get_rob_id1(get_rob_id1), .get_rob_id2(get_rob_id2),
    .get_ready1(get_ready1), .get_ready2(get_ready2),
    .get_value1(get_value1), .get_value2(get_value2)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic check_src1(input string tag, input logic rdy_e, input logic [31:0] val_e,
                            input logic [ROB_W-1:0] id_e);
    check({tag, ".ready1"}, {31'd0, rs1_ready}, {31'd0, rdy_e});
    check({tag, ".value1"}, rs1_value, val_e);
    check({tag, ".rob_id1"}, {28'd0, rs1_rob_id}, {28'd0, id_e});
  endtask

  task automatic check_src2(input string tag, input logic rdy_e, input logic [31:0] val_e,
                            input logic [ROB_W-1:0] id_e);
    check({tag, ".ready2"}, {31'd0, rs2_ready}, {31'd0, rdy_e});
    check({tag, ".value2"}, rs2_value, val_e);
    check({tag, ".rob_id2"}, {28'd0, rs2_rob_id}, {28'd0, id_e});
  endtask

  // Inputs change on the falling edge; one rising edge passes per tick.
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; issue_en = 1'b0;
    issue_rd = '0; issue_rob_id = '0; commit_rd = '0; commit_rob_id = '0; commit_value = '0;
    rs1 = '0; rs2 = '0; get_ready1 = 1'b0; get_ready2 = 1'b0; get_value1 = '0; get_value2 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    rs1 = 5'd3; rs2 = 5'd0; #1;
    check_src1("reset", 1'b1, 32'd0, 4'd0);
    check_src2("reset", 1'b1, 32'd0, 4'd0);

    // Rename x5 -> tag 2; same-cycle read still sees old mapping
    issue_en = 1'b1; issue_rd = 5'd5; issue_rob_id = 4'd2; rs1 = 5'd5; #1;
    check_src1("issue_same_cycle", 1'b1, 32'd0, 4'd0);
    tick();
    issue_en = 1'b0; #1;
    check_src1("renamed", 1'b0, 32'd0, 4'd2);
    check("renamed.get_rob_id1", {28'd0, get_rob_id1}, 32'd2);
    get_ready1 = 1'b1; get_value1 = 32'h55; #1;
    check_src1("rob_forward", 1'b1, 32'h55, 4'd0);

    // Commit bypass, then committed value from the register
    get_ready1 = 1'b0; get_value1 = '0;
    commit_rd = 5'd5; commit_rob_id = 4'd2; commit_value = 32'hDEADBEEF; #1;
    check_src1("commit_bypass", 1'b1, 32'hDEADBEEF, 4'd0);
    tick();
    commit_rd = 5'd0; commit_value = '0; #1;
    check_src1("committed", 1'b1, 32'hDEADBEEF, 4'd0);

    // Stale commit keeps newer rename; issue beats commit busy clear
    issue_en = 1'b1; issue_rd = 5'd7; issue_rob_id = 4'd1;
    tick();
    issue_rob_id = 4'd4;
    tick();
    issue_en = 1'b0;
    commit_rd = 5'd7; commit_rob_id = 4'd1; commit_value = 32'd9;
    tick();
    commit_rd = 5'd0; rs2 = 5'd7; #1;
    check_src2("stale_commit", 1'b0, 32'd0, 4'd4);
    issue_en = 1'b1; issue_rd = 5'd7; issue_rob_id = 4'd6;
    commit_rd = 5'd7; commit_rob_id = 4'd4; commit_value = 32'h44; #1;
    check_src2("issue_commit_bypass", 1'b1, 32'h44, 4'd0);
    tick();
    issue_en = 1'b0; commit_rd = 5'd0; commit_value = '0; #1;
    check_src2("issue_wins", 1'b0, 32'd0, 4'd6);

    // Rename x1..x3, then clear with concurrent issue and stale commit
    issue_en = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      issue_rd = 5'(r); issue_rob_id = 4'(r);
      tick();
    end
    issue_en = 1'b0; rs1 = 5'd1; #1;
    check_src1("pre_clear", 1'b0, 32'd0, 4'd1);
    clear = 1'b1; issue_en = 1'b1; issue_rd = 5'd8; issue_rob_id = 4'd5;
    commit_rd = 5'd2; commit_rob_id = 4'd7; commit_value = 32'h10;
    tick();
    clear = 1'b0; issue_en = 1'b0; commit_rd = 5'd0; commit_value = '0;
    rs1 = 5'd3; rs2 = 5'd2; #1;
    check_src1("clear_x3", 1'b1, 32'd0, 4'd0);
    check_src2("clear_x2", 1'b1, 32'h10, 4'd0);
    rs1 = 5'd8; rs2 = 5'd7; #1;
    check_src1("clear_x8", 1'b1, 32'd0, 4'd0);
    check_src2("clear_x7", 1'b1, 32'h44, 4'd0);

    // rdy low: nothing changes
    rdy = 1'b0; issue_en = 1'b1; issue_rd = 5'd9; issue_rob_id = 4'd3;
    commit_rd = 5'd9; commit_rob_id = 4'd3; commit_value = 32'h99;
    rs1 = 5'd9;
    tick();
    tick();
    rdy = 1'b1; issue_en = 1'b0; commit_rd = 5'd0; commit_value = '0; #1;
    check_src1("stall_x9", 1'b1, 32'd0, 4'd0);

    // x0 never renamed
    issue_en = 1'b1; issue_rd = 5'd0; issue_rob_id = 4'd3;
    tick();
    issue_en = 1'b0; rs1 = 5'd0; #1;
    check_src1("x0", 1'b1, 32'd0, 4'd0);

    // Mid-stream asynchronous reset
    issue_en = 1'b1; issue_rd = 5'd4; issue_rob_id = 4'd9;
    tick();
    issue_en = 1'b0; rs1 = 5'd4; rs2 = 5'd2; #1;
    check_src1("pre_rst", 1'b0, 32'd0, 4'd9);
    rst = 1'b1; #1;
    check_src1("async_rst", 1'b1, 32'd0, 4'd0);
    check_src2("async_rst", 1'b1, 32'd0, 4'd0);
    tick();
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
